// File: rtl/regfile_pkg.sv
// Shared register-file constants for the register file and its write-back scheduler.
// No logic; no latency; no backpressure.
// Single source of truth for register index/data widths.
package regfile_pkg;
  localparam int RegNumWidth = 5;
  localparam int NumRegs     = 32;
  localparam int DataWidth   = 32;
  localparam logic [RegNumWidth-1:0] RegZero = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr, wrapping modulo NumReq.
// Purely combinational, zero latency.
// Never grants an invalid requester; grant is all-zero when nothing is valid.
module rr_arbiter #(
  parameter int NumReq   = 3,
  parameter int IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   reqValid,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   grant,
  output logic [IdxWidth-1:0] grantIdx
);
  logic [IdxWidth-1:0] idx;
  logic                found;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = ptr;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && reqValid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grantIdx   = idx;
      end
      idx = (idx == IdxWidth'(NumReq - 1)) ? '0 : idx + IdxWidth'(1);
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among NumReq write-back requesters and tracks pending destinations.
// Accepted write appears on the write port one cycle later; readHazard is combinational.
// One transfer per cycle via one-hot reqReady; losers hold their request until granted.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NumReq    = 3,
  parameter int DataWidth = regfile_pkg::DataWidth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NumReq-1:0]             reqValid,
  input  logic [NumReq*RegNumWidth-1:0] reqNum,
  input  logic [NumReq*DataWidth-1:0]   reqData,
  output logic [NumReq-1:0]             reqReady,
  input  logic                          issueValid,
  input  logic [RegNumWidth-1:0]        issueNum,
  input  logic [RegNumWidth-1:0]        readNum0,
  input  logic [RegNumWidth-1:0]        readNum1,
  output logic                          readHazard,
  output logic                          regsWriteEnable,
  output logic [RegNumWidth-1:0]        regWriteNum,
  output logic [DataWidth-1:0]          regWriteData,
  output logic [NumRegs-1:0]            pendingMask
);
  localparam int IdxWidth = $clog2(NumReq);

  logic [IdxWidth-1:0]    ptr;
  logic [IdxWidth-1:0]    grantIdx;
  logic [NumReq-1:0]      grant;
  logic                   transfer;
  logic [RegNumWidth-1:0] winNum;
  logic [DataWidth-1:0]   winData;
  logic [NumRegs-1:0]     pending;
  logic [NumRegs-1:0]     pendingNext;

  rr_arbiter #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) uArb (
    .reqValid (reqValid),
    .ptr      (ptr),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  // Grants are suppressed while reset is held so nothing is handshaken into a clearing block.
  assign reqReady = reset ? grant : '0;
  assign transfer = |reqReady;

  always_comb begin
    winNum  = '0;
    winData = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        winNum  = reqNum[i*RegNumWidth +: RegNumWidth];
        winData = reqData[i*DataWidth +: DataWidth];
      end
    end
  end

  // Set is applied after clear: a same-cycle issue belongs to a younger producer.
  always_comb begin
    pendingNext = pending;
    if (transfer && (winNum != RegZero)) pendingNext[winNum] = 1'b0;
    if (issueValid && (issueNum != RegZero)) pendingNext[issueNum] = 1'b1;
    pendingNext[RegZero] = 1'b0;
  end

  assign readHazard  = ((readNum0 != RegZero) && pending[readNum0]) ||
                       ((readNum1 != RegZero) && pending[readNum1]);
  assign pendingMask = pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr             <= '0;
      pending         <= '0;
      regsWriteEnable <= 1'b0;
      regWriteNum     <= '0;
      regWriteData    <= '0;
    end else begin
      pending         <= pendingNext;
      regsWriteEnable <= transfer && (winNum != RegZero);
      if (transfer) begin
        ptr          <= (grantIdx == IdxWidth'(NumReq - 1)) ? '0 : grantIdx + IdxWidth'(1);
        regWriteNum  <= winNum;
        regWriteData <= winData;
      end
    end
  end
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 three-port register file: it shares the register file's single write port between several write-back requesters and tracks in-flight destination registers. Requesters are the ALU, load and multi-cycle units. Arbitration is round-robin. The winning write is registered and presented to the register file's write port one cycle later. A 32-bit pending scoreboard drives a read-hazard flag that decode uses to stall.

## Interface
Parameters:
- NumReq, 3, number of write-back requesters (2..8)
- DataWidth, 32, register data width

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- reqValid  in  NumReq  per-requester write-back request
- reqNum  in  NumReq*5  destination register per requester; requester i at bits [5i+4:5i]
- reqData  in  NumReq*DataWidth  write data per requester; requester i at bits [DataWidth*i+DataWidth-1 : DataWidth*i]
- reqReady  out  NumReq  one-hot grant, combinational; transfer when reqValid[i] && reqReady[i]
- issueValid  in  1  an instruction with destination issueNum is issued
- issueNum  in  5  destination of the issued instruction
- readNum0, readNum1  in  5  source registers being decoded
- readHazard  out  1  combinational; 1 if either source is pending
- regsWriteEnable  out  1  registered write-port enable to the register file
- regWriteNum  out  5  registered write-port register number
- regWriteData  out  DataWidth  registered write-port data
- pendingMask  out  32  scoreboard state; bit 0 is always 0

## Operation
- **Arbitration**
  - The round-robin pointer `ptr` ranges over 0..NumReq-1.
  - The grant goes to the first i with reqValid[i] set, searching ptr, ptr+1, … modulo NumReq.
  - At most one grant per cycle. No grant is issued when no request is valid.
  - On an accepted transfer from requester g, ptr ← (g+1) mod NumReq. Otherwise ptr holds.
- **Handshake**
  - A requester holds reqValid, reqNum and reqData stable until it is granted.
  - reqReady[i] never asserts without reqValid[i].
  - The scheduler accepts one transfer per cycle, back-to-back, with no bubbles.
- **Write-port output register**
  - On a transfer: regWriteNum ← reqNum[g] and regWriteData ← reqData[g].
  - regsWriteEnable ← (reqNum[g] != 0). A write to x0 is accepted and consumed but never enabled.
  - With no transfer, regsWriteEnable ← 0. regWriteNum and regWriteData hold their previous values.
- **Scoreboard** (pending[31:0])
  - Set: issueValid && issueNum != 0 sets pending[issueNum].
  - Clear: a transfer with reqNum[g] != 0 clears pending[reqNum[g]].
  - Set and clear of the same register in the same cycle: set wins, because the new producer is younger.
  - pending[0] is held at 0.
  - Clearing a bit that is not pending is harmless.
- **Hazard**
  - readHazard = (readNum0 != 0 && pending[readNum0]) || (readNum1 != 0 && pending[readNum1]).

## Timing
- Reset values: ptr=0, pending=0, regsWriteEnable=0, regWriteNum=0, regWriteData=0, pendingMask=0.
  - reqReady and readHazard are combinational and therefore 0 during reset.
  - Reset asserted mid-operation drops any accepted-but-unwritten output immediately.
  - All scoreboard bits are lost on reset.
- Latency:
  - Transfer on posedge N → regsWriteEnable high during cycle N+1.
  - The register file writes at the falling edge inside cycle N+1.
  - pending clears at posedge N. A decode read in cycle N+1 is sampled at posedge N+2, after the write, so no bypass is required.
- Throughput is one write per cycle.
- Fairness: a continuously valid requester is granted within NumReq cycles.
- Boundaries:
  - An issue and a write-back to different registers in the same cycle both take effect.
  - A second issue to an already-pending register keeps the bit set. The first write-back clears it; the team accepts this because issue stalls on WAW upstream.

## Structure
- Shared package `regfile_pkg` holds:
  - RegNumWidth=5
  - NumRegs=32
  - DataWidth=32 (one source for the register file and this block)
  - the x0 index constant
- One sub-module, `rr_arbiter`: parameter NumReq; inputs reqValid and ptr; outputs one-hot grant and granted index.
  - It is purely combinational.
  - The pointer register, scoreboard and output register live in the top block.

## Test plan
- **Single write:** reset, then requester 1 presents num=5, data=0xDEADBEEF for one cycle.
  - reqReady=3'b010 that cycle.
  - Next cycle: regsWriteEnable=1, regWriteNum=5, regWriteData=0xDEADBEEF.
  - The cycle after: regsWriteEnable=0.
- **Round-robin:** all three requesters valid continuously with nums 1, 2, 3.
  - Grant sequence is 0, 1, 2, 0, 1, 2.
  - Outputs show regWriteNum 1, 2, 3, 1, … one cycle delayed.
- **x0 write:** a requester presents num=0, data=0x1234.
  - The request is granted.
  - regsWriteEnable stays 0 the next cycle.
  - pendingMask is unchanged.
- **Scoreboard and hazard:**
  - Issue num=7, then set readNum0=7: readHazard=1 and pendingMask=0x80.
  - A write-back of 7 clears the bit; readHazard=0 the cycle after the transfer.
  - In a separate cycle, issue 7 while write-back 7 is accepted: the bit stays set.
- **Reset mid-flight:**
  - pendingMask=0x0000_00F0 with a transfer just accepted.
  - Drop reset low between edges: all outputs are 0 immediately; ptr=0 after release.
  - The next grant with all requesters valid goes to requester 0.
